rv32v_dcache_responder: RTL and testbench

// - Responder end of the vector memory stage's cache interface. Accepts one word-aligned

---
 rtl/rv32v_dcache_responder.sv | 213 +++++++++++++++++++++
 tb/tb_rv32v_dcache_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_dcache_responder.sv
// -----------------------------------------------------------------------------
// rv32v_dcache_responder
// Responder end of the vector memory stage's cache interface. One word-aligned
// read or write is accepted at a time and answered with a single-cycle dhit
// after a fixed latency. Every MISS_PERIOD-th accepted request is a miss and
// costs MISS_PENALTY extra cycles. Backing store is word addressed with
// byte-lane merging on writes; reads always return the full word.
//
// Ports
//   CLK         clock, rising edge
//   nRST        asynchronous active-low reset
//   ren / wen   read / write request, held by the initiator until dhit
//   dmemaddr    byte address, word index = dmemaddr[ADDR_W+1:2]
//   dmemstore   lane-aligned write data
//   byte_ena    write lane enables
//   dhit        one-cycle completion pulse
//   dmemload    read word, meaningful only while dhit is high
//   req_err     one-cycle pulse when ren and wen were accepted together
//   access_cnt  number of completed transactions (wraps)
// -----------------------------------------------------------------------------
module rv32v_dcache_responder #(
   parameter int ADDR_W       = 10,
   parameter int HIT_LATENCY  = 1,
   parameter int MISS_PERIOD  = 0,
   parameter int MISS_PENALTY = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ren,
   input  logic        wen,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic [3:0]  byte_ena,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        req_err,
   output logic [31:0] access_cnt
);

   localparam int          DEPTH    = 2 ** ADDR_W;
   localparam logic [15:0] LAT_HIT  = 16'(HIT_LATENCY);
   localparam logic [15:0] LAT_MISS = 16'(HIT_LATENCY + MISS_PENALTY);
   localparam logic [31:0] MISS_PER = 32'(MISS_PERIOD);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [31:0]         req_cnt_q, req_cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         store_q, store_d;
   logic [3:0]          be_q, be_d;
   logic                wr_q, wr_d;
   logic                dhit_q, dhit_d;
   logic                req_err_q, req_err_d;
   logic [31:0]         access_cnt_q, access_cnt_d;
   logic [31:0]         dmemload_q, dmemload_d;

   logic [31:0]         mem_q [DEPTH];

   logic                req_s;
   logic                miss_s;
   logic [15:0]         lat_s;
   logic                commit_s;
   logic [ADDR_W-1:0]   commit_idx_s;
   logic                commit_wr_s;
   logic [3:0]          commit_be_s;
   logic [31:0]         commit_store_s;
   logic [31:0]         rd_word_s;
   logic [31:0]         merged_s;
   logic                unused_s;

   assign unused_s = ^{dmemaddr[31:ADDR_W+2], dmemaddr[1:0]};

   assign req_s  = ren | wen;
   // The request counter holds the number of accepted requests modulo the
   // period, so the request that would bring it to MISS_PERIOD is the miss.
   assign miss_s = (MISS_PER != 32'd0) && ((req_cnt_q + 32'd1) == MISS_PER);
   assign lat_s  = miss_s ? LAT_MISS : LAT_HIT;

   // Next-state, latching and commit control for the request FSM.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      req_cnt_d      = req_cnt_q;
      addr_d         = addr_q;
      store_d        = store_q;
      be_d           = be_q;
      wr_d           = wr_q;
      dhit_d         = 1'b0;
      req_err_d      = 1'b0;
      access_cnt_d   = access_cnt_q;
      commit_s       = 1'b0;
      commit_idx_s   = addr_q;
      commit_wr_s    = wr_q;
      commit_be_s    = be_q;
      commit_store_s = store_q;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               addr_d    = dmemaddr[ADDR_W+1:2];
               store_d   = dmemstore;
               be_d      = byte_ena;
               wr_d      = wen;        // ren&wen is treated as a write
               req_err_d = ren & wen;
               if (miss_s) begin
                  req_cnt_d = 32'd0;
               end else begin
                  req_cnt_d = req_cnt_q + 32'd1;
               end
               if (lat_s <= 16'd1) begin
                  // Single-cycle access commits straight from the live inputs,
                  // since the latched copies only appear after this edge.
                  state_d        = ST_RESP;
                  dhit_d         = 1'b1;
                  commit_s       = 1'b1;
                  commit_idx_s   = dmemaddr[ADDR_W+1:2];
                  commit_wr_s    = wen;
                  commit_be_s    = byte_ena;
                  commit_store_s = dmemstore;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = lat_s - 16'd1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!req_s) begin
               state_d = ST_IDLE;      // initiator withdrew: nothing commits
            end else if (cnt_q <= 16'd1) begin
               state_d  = ST_RESP;
               dhit_d   = 1'b1;
               commit_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_RESP: begin
            state_d      = ST_IDLE;
            access_cnt_d = access_cnt_q + 32'd1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read-modify-write merge of the enabled lanes and read data capture.
   always_comb begin
      rd_word_s = mem_q[commit_idx_s];
      merged_s  = rd_word_s;
      for (int k = 0; k < 4; k++) begin
         if (commit_be_s[k]) begin
            merged_s[8*k +: 8] = commit_store_s[8*k +: 8];
         end else begin
            merged_s[8*k +: 8] = rd_word_s[8*k +: 8];
         end
      end
      if (commit_s && !commit_wr_s) begin
         dmemload_d = rd_word_s;
      end else begin
         dmemload_d = dmemload_q;
      end
   end

   // Control and output registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 16'd0;
         req_cnt_q    <= 32'd0;
         addr_q       <= '0;
         store_q      <= 32'd0;
         be_q         <= 4'd0;
         wr_q         <= 1'b0;
         dhit_q       <= 1'b0;
         req_err_q    <= 1'b0;
         access_cnt_q <= 32'd0;
         dmemload_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_cnt_q    <= req_cnt_d;
         addr_q       <= addr_d;
         store_q      <= store_d;
         be_q         <= be_d;
         wr_q         <= wr_d;
         dhit_q       <= dhit_d;
         req_err_q    <= req_err_d;
         access_cnt_q <= access_cnt_d;
         dmemload_q   <= dmemload_d;
      end
   end

   // Backing store; contents survive reset, and no write lands while reset is held.
   always_ff @(posedge CLK) begin
      if (commit_s && commit_wr_s && nRST) begin
         mem_q[commit_idx_s] <= merged_s;
      end
   end

   assign dhit       = dhit_q;
   assign dmemload   = dmemload_q;
   assign req_err    = req_err_q;
   assign access_cnt = access_cnt_q;

endmodule

// File: tb/tb_rv32v_dcache_responder.sv
// -----------------------------------------------------------------------------
// Bench for rv32v_dcache_responder. Two instances: dut 0 with single-cycle
// hits and no misses, dut 1 with HIT_LATENCY=3, MISS_PERIOD=2, MISS_PENALTY=4.
// Drivers push expected responses into per-instance queues; a monitor pops
// and compares whenever dhit is seen.
// -----------------------------------------------------------------------------
module tb_rv32v_dcache_responder;

   localparam int HL  [2] = '{1, 3};
   localparam int MP  [2] = '{0, 2};
   localparam int PEN [2] = '{4, 4};

   logic        clk = 1'b0;
   logic        nrst    [2];
   logic        ren     [2];
   logic        wen     [2];
   logic [31:0] addr    [2];
   logic [31:0] store   [2];
   logic [3:0]  be      [2];
   logic        dhit    [2];
   logic [31:0] load    [2];
   logic        req_err [2];
   logic [31:0] acnt    [2];

   always #5 clk = ~clk;

   rv32v_dcache_responder #(.ADDR_W(10), .HIT_LATENCY(1), .MISS_PERIOD(0), .MISS_PENALTY(4)) dut0 (
      .CLK(clk), .nRST(nrst[0]), .ren(ren[0]), .wen(wen[0]), .dmemaddr(addr[0]),
      .dmemstore(store[0]), .byte_ena(be[0]), .dhit(dhit[0]), .dmemload(load[0]),
      .req_err(req_err[0]), .access_cnt(acnt[0]));

   rv32v_dcache_responder #(.ADDR_W(10), .HIT_LATENCY(3), .MISS_PERIOD(2), .MISS_PENALTY(4)) dut1 (
      .CLK(clk), .nRST(nrst[1]), .ren(ren[1]), .wen(wen[1]), .dmemaddr(addr[1]),
      .dmemstore(store[1]), .byte_ena(be[1]), .dhit(dhit[1]), .dmemload(load[1]),
      .req_err(req_err[1]), .access_cnt(acnt[1]));

   typedef struct {
      int unsigned cyc;
      bit          rd;
      bit          chk;
      logic [31:0] data;
      bit          err;
   } exp_t;

   exp_t        sbq [2][$];
   logic [31:0] mmem  [2][1024];
   bit   [3:0]  known [2][1024];
   int unsigned reqn [2];
   int unsigned comp [2];
   int unsigned prev_done [2];
   bit          err_seen [2];
   int unsigned cyc = 0;
   int          checks = 0;
   int          fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int d, input int unsigned n);
      bit miss;
      miss = (MP[d] != 0) && ((n % MP[d]) == 0);
      return HL[d] + (miss ? PEN[d] : 0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idle(input int d, input int n);
      ren[d] = 1'b0;
      wen[d] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Present one transaction at the current negedge and hold it until dhit.
   task automatic issue(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] s, input logic [3:0] b);
      exp_t        e;
      int unsigned t;
      int          idx;
      bit          seen;
      ren[d] = r; wen[d] = w; addr[d] = a; store[d] = s; be[d] = b;
      // The cycle right after a response is not accepting.
      t = (cyc == prev_done[d]) ? cyc + 2 : cyc + 1;
      reqn[d]++;
      e.cyc  = t + lat(d, reqn[d]) - 1;
      e.err  = r && w;
      idx    = int'(a[11:2]);
      e.data = 32'd0;
      e.chk  = 1'b0;
      e.rd   = 1'b0;
      if (w) begin
         for (int k = 0; k < 4; k++) begin
            if (b[k]) begin
               mmem[d][idx][8*k +: 8] = s[8*k +: 8];
               known[d][idx][k] = 1'b1;
            end
         end
      end else begin
         e.rd   = 1'b1;
         e.chk  = (known[d][idx] == 4'hF);
         e.data = mmem[d][idx];
      end
      comp[d]++;
      sbq[d].push_back(e);
      seen = 1'b0;
      for (int n = 0; n < 64 && !seen; n++) begin
         @(negedge clk);
         if (dhit[d] === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         fails++;
         $display("FAIL dut%0d dhit_timeout actual=none required=dhit_by_cyc_%0d", d, e.cyc);
         if (sbq[d].size() != 0) void'(sbq[d].pop_front());
      end
      prev_done[d] = cyc;
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (req_err[d] === 1'b1) err_seen[d] = 1'b1;
         if (dhit[d] === 1'b1) begin
            checks++;
            if (sbq[d].size() == 0) begin
               fails++;
               $display("FAIL dut%0d unexpected_dhit actual=dhit_at_cyc_%0d required=no_dhit", d, cyc);
            end else begin
               e = sbq[d].pop_front();
               checks++;
               if (cyc != e.cyc) begin
                  fails++;
                  $display("FAIL dut%0d latency actual=cyc_%0d required=cyc_%0d", d, cyc, e.cyc);
               end
               checks++;
               if (err_seen[d] != e.err) begin
                  fails++;
                  $display("FAIL dut%0d req_err actual=%0b required=%0b", d, err_seen[d], e.err);
               end
               if (e.rd && e.chk) begin
                  checks++;
                  if (load[d] !== e.data) begin
                     fails++;
                     $display("FAIL dut%0d dmemload actual=%h required=%h", d, load[d], e.data);
                  end
               end
            end
            err_seen[d] = 1'b0;
         end
      end
   end

   logic [3:0] be_tab [8];

   initial begin
      int nd;
      be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
      for (int d = 0; d < 2; d++) begin
         nrst[d] = 1'b0; ren[d] = 1'b0; wen[d] = 1'b0;
         addr[d] = 32'd0; store[d] = 32'd0; be[d] = 4'd0;
         reqn[d] = 0; comp[d] = 0; prev_done[d] = 32'hFFFF_FFFF; err_seen[d] = 1'b0;
         for (int i = 0; i < 1024; i++) known[d][i] = 4'h0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("dut%0d reset_dhit", d), {31'd0, dhit[d]}, 32'd0);
         chk($sformatf("dut%0d reset_dmemload", d), load[d], 32'd0);
         chk($sformatf("dut%0d reset_req_err", d), {31'd0, req_err[d]}, 32'd0);
         chk($sformatf("dut%0d reset_access_cnt", d), acnt[d], 32'd0);
      end
      nrst[0] = 1'b1; nrst[1] = 1'b1;
      repeat (2) @(negedge clk);

      // T1 / T2 / T5 on the single-cycle instance.
      issue(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
      issue(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      idle(0, 2);
      chk("dut0 t1_access_cnt", acnt[0], 32'd2);
      issue(0, 1'b0, 1'b1, 32'h40, 32'h0000AA00, 4'b0010);
      issue(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      idle(0, 1);
      chk("dut0 t2_merged_word", mmem[0][16], 32'hDEADAAEF);
      issue(0, 1'b1, 1'b1, 32'h80, 32'h12345678, 4'hF);
      issue(0, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
      idle(0, 2);

      // T3: four back-to-back reads, miss every second request.
      issue(1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
      issue(1, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
      issue(1, 1'b1, 1'b0, 32'h108, 32'h0, 4'h0);
      issue(1, 1'b1, 1'b0, 32'h10C, 32'h0, 4'h0);
      idle(1, 2);
      chk("dut1 t3_access_cnt", acnt[1], 32'd4);

      // T4: abort after one cycle, then a normal read.
      issue(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
      idle(1, 3);
      ren[1] = 1'b1; addr[1] = 32'h40;
      reqn[1]++;
      @(negedge clk);
      ren[1] = 1'b0;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         if (dhit[1] === 1'b1) nd++;
      end
      chk("dut1 t4_abort_dhits", nd, 32'd0);
      issue(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      idle(1, 2);

      // T6: reset during the wait of a write; the old word must survive.
      issue(1, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
      idle(1, 3);
      wen[1] = 1'b1; addr[1] = 32'h10; store[1] = 32'hFFFFFFFF; be[1] = 4'hF;
      @(negedge clk);
      nrst[1] = 1'b0;
      #1;
      chk("dut1 t6_dhit_in_reset", {31'd0, dhit[1]}, 32'd0);
      chk("dut1 t6_access_cnt_in_reset", acnt[1], 32'd0);
      wen[1] = 1'b0;
      reqn[1] = 0; comp[1] = 0; err_seen[1] = 1'b0;
      @(negedge clk);
      nrst[1] = 1'b1;
      idle(1, 2);
      issue(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      idle(1, 2);
      chk("dut1 t6_access_cnt", acnt[1], 32'd1);

      // Randomized traffic with aliased addresses and legal lane patterns.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) begin
            issue(d, 1'b0, 1'b1, 32'h200 + 32'(i) * 32'd4, $urandom, 4'hF);
         end
         for (int i = 0; i < 40; i++) begin
            int unsigned op;
            logic [31:0] a;
            a  = ($urandom & 32'hFFFF_F000) | 32'h200 | (32'($urandom_range(0, 7)) << 2);
            op = $urandom_range(0, 9);
            if (op < 4) begin
               issue(d, 1'b1, 1'b0, a, $urandom, 4'h0);
            end else if (op < 8) begin
               issue(d, 1'b0, 1'b1, a, $urandom, be_tab[$urandom_range(0, 7)]);
            end else if (op == 8) begin
               issue(d, 1'b1, 1'b1, a, $urandom, be_tab[$urandom_range(0, 7)]);
            end else begin
               issue(d, 1'b0, 1'b1, a, $urandom, 4'h0);
            end
            if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(1, 3));
         end
         idle(d, 3);
         chk($sformatf("dut%0d final_access_cnt", d), acnt[d], comp[d]);
         chk($sformatf("dut%0d scoreboard_drained", d), sbq[d].size(), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
